// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble output path: access type encodings,
// the invalid cycle marker and the serializer FSM state type.
package bubble_pkg;

    localparam logic [2:0] ACC_RST  = 3'b000;
    localparam logic [2:0] ACC_STBY = 3'b001;
    localparam logic [2:0] ACC_BOOT = 3'b110;
    localparam logic [2:0] ACC_USER = 3'b111;
    localparam logic [2:0] ACC_IDLE = 3'b100;
    localparam logic [2:0] ACC_SWAP = 3'b101;

    // Cycle number reported by the timing generator for invalid/preamble cycles
    localparam logic [12:0] BOUT_INVALID_CYCLE = 13'd8191;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRIVE = 2'd3
    } bout_state_e;

endpackage

// File: rtl/tick_edge_detect.sv
// Quarter-cycle phase decoder for the bubble output serializer.
// cycle_start_o is a registered one-cycle strobe on a change of the ticks
// to 0; drive_win_o (ticks 1 or 2) and drive_end_o (ticks 3) qualify the
// data window directly from the live ticks so the data lines follow the
// phase with a single register stage.
module tick_edge_detect (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] ticks_i,
    output logic       cycle_start_o,
    output logic       drive_win_o,
    output logic       drive_end_o
);

    logic [1:0] ticks_q;
    logic       cycle_start_q;

    // Keep the previous phase and register the change-to-zero strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ticks_q       <= 2'd3;
            cycle_start_q <= 1'b0;
        end else begin
            ticks_q       <= ticks_i;
            cycle_start_q <= (ticks_i == 2'd0) && (ticks_q != 2'd0);
        end
    end

    assign cycle_start_o = cycle_start_q;
    assign drive_win_o   = (ticks_i == 2'd1) || (ticks_i == 2'd2);
    assign drive_end_o   = (ticks_i == 2'd3);

endmodule

// File: rtl/bubble_output_serializer.sv
// Bubble output serializer: for each valid bubble output cycle, fetches one
// byte from the page/boot buffer, selects a nibble and drives it onto DOUT
// during ticks 1-2. Optional fetch timeout with DERR pulse is built when the
// macro BOUT_TIMEOUT_EN is defined; otherwise DERR stays 0.
module bubble_output_serializer
    import bubble_pkg::*;
#(
    parameter int BUF_LAT_MAX = 100
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic [2:0]  ACCTYPE,
    input  logic [12:0] BOUTCYCLENUM,
    input  logic [1:0]  BOUTTICKS,
    output logic        BUF_RD,
    output logic [12:0] BUF_ADDR,
    input  logic        BUF_ACK,
    input  logic [7:0]  BUF_DATA,
    output logic [3:0]  DOUT,
    output logic        DERR
);

    bout_state_e state_q, state_d;
    logic [12:0] addr_q, addr_d;
    logic        sel_q, sel_d;
    logic [3:0]  nib_q, nib_d;
    logic [3:0]  dout_q, dout_d;
    logic        buf_rd_q, buf_rd_d;
    logic        derr_q, derr_d;

    logic        cycle_start;
    logic        drive_win;
    logic        drive_end;
    logic        start_evt;
    logic        tmo_hit;

    tick_edge_detect u_tick_edge_detect (
        .clk_i         (MCLK),
        .rst_ni        (nRESET),
        .ticks_i       (BOUTTICKS),
        .cycle_start_o (cycle_start),
        .drive_win_o   (drive_win),
        .drive_end_o   (drive_end)
    );

    // A fetch only starts for data-carrying access types with a real cycle number
    assign start_evt = cycle_start && ACCTYPE[1] && (BOUTCYCLENUM != BOUT_INVALID_CYCLE);

`ifdef BOUT_TIMEOUT_EN
    localparam int CNT_W = $clog2(BUF_LAT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo_hit = (cnt_q == CNT_W'(BUF_LAT_MAX - 1));

    // Count MCLKs spent waiting in S_REQ; restarts on every new request
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_REQ) && !start_evt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next state, latched request fields and next registered outputs
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        nib_d   = nib_q;
        derr_d  = 1'b0;

        if (!ACCTYPE[1]) begin
            state_d = S_IDLE;
        end else if (start_evt) begin
            // Also covers a restart when the tick sequence glitches mid-fetch
            state_d = S_REQ;
            addr_d  = {(ACCTYPE == ACC_USER), BOUTCYCLENUM[12:1]};
            sel_d   = BOUTCYCLENUM[0];
        end else begin
            case (state_q)
                S_REQ: begin
                    if (drive_end) begin
                        state_d = S_IDLE;
                    end else if (BUF_ACK) begin
                        nib_d   = sel_q ? BUF_DATA[7:4] : BUF_DATA[3:0];
                        state_d = drive_win ? S_DRIVE : S_WAIT;
                    end else if (tmo_hit) begin
                        state_d = S_IDLE;
                        derr_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (drive_end) begin
                        state_d = S_IDLE;
                    end else if (drive_win) begin
                        state_d = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (drive_end) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        buf_rd_d = (state_d == S_REQ);
        dout_d   = ((state_d == S_DRIVE) && drive_win) ? nib_d : 4'd0;
    end

    // State and output registers
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            addr_q   <= 13'd0;
            sel_q    <= 1'b0;
            nib_q    <= 4'd0;
            dout_q   <= 4'd0;
            buf_rd_q <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            nib_q    <= nib_d;
            dout_q   <= dout_d;
            buf_rd_q <= buf_rd_d;
            derr_q   <= derr_d;
        end
    end

    assign BUF_RD   = buf_rd_q;
    assign BUF_ADDR = addr_q;
    assign DOUT     = dout_q;
    assign DERR     = derr_q;

endmodule

// File: tb/tb_bubble_output_serializer.sv
// Self-checking bench for bubble_output_serializer: directed scenarios with
// literal expectations plus randomized bubble cycles compared every MCLK
// against a behavioural model of the fetch/drive rules.
module tb_bubble_output_serializer;
    import bubble_pkg::*;

    localparam int LAT = 100;
    localparam int PH  = 120;
`ifdef BOUT_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        MCLK = 1'b0;
    logic        nRESET;
    logic [2:0]  ACCTYPE;
    logic [12:0] BOUTCYCLENUM;
    logic [1:0]  BOUTTICKS;
    logic        BUF_RD;
    logic [12:0] BUF_ADDR;
    logic        BUF_ACK;
    logic [7:0]  BUF_DATA;
    logic [3:0]  DOUT;
    logic        DERR;

    always #5 MCLK = ~MCLK;

    bubble_output_serializer #(.BUF_LAT_MAX(LAT)) dut (
        .MCLK         (MCLK),
        .nRESET       (nRESET),
        .ACCTYPE      (ACCTYPE),
        .BOUTCYCLENUM (BOUTCYCLENUM),
        .BOUTTICKS    (BOUTTICKS),
        .BUF_RD       (BUF_RD),
        .BUF_ADDR     (BUF_ADDR),
        .BUF_ACK      (BUF_ACK),
        .BUF_DATA     (BUF_DATA),
        .DOUT         (DOUT),
        .DERR         (DERR)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:8191];
    int         ack_lat  = 3;
    bit         spurious = 1'b0;

    // monitor flags
    bit          rd_seen, dout_nz, derr_seen;
    logic [12:0] last_addr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks whether the current bubble cycle owns a fetch, whether
    // its nibble has arrived, and derives the outputs from the phase rules.
    bit          m_own, m_got, m_sel, m_start_dly, start_now;
    logic [3:0]  m_nib;
    logic [1:0]  m_prev_ticks;
    int          m_wait;
    logic        exp_rd, exp_derr;
    logic [3:0]  exp_dout;
    logic [12:0] exp_addr;

    task automatic m_reset();
        m_own = 0; m_got = 0; m_sel = 0; m_start_dly = 0; m_nib = 0;
        m_prev_ticks = 2'd3; m_wait = 0;
        exp_rd = 0; exp_derr = 0; exp_dout = 0; exp_addr = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge MCLK);
            if (!nRESET) begin
                m_reset();
                continue;
            end
            start_now    = m_start_dly && ACCTYPE[1] && (BOUTCYCLENUM != 13'd8191);
            m_start_dly  = (BOUTTICKS == 2'd0) && (m_prev_ticks != 2'd0);
            m_prev_ticks = BOUTTICKS;
            exp_derr     = 0;
            if (!ACCTYPE[1]) begin
                m_own = 0;
            end else if (start_now) begin
                m_own    = 1;
                m_got    = 0;
                m_wait   = 0;
                exp_addr = {(ACCTYPE == 3'b111), BOUTCYCLENUM[12:1]};
                m_sel    = BOUTCYCLENUM[0];
            end else if (m_own && !m_got) begin
                if (BOUTTICKS == 2'd3) begin
                    m_own = 0;
                end else if (BUF_ACK) begin
                    m_got = 1;
                    m_nib = m_sel ? BUF_DATA[7:4] : BUF_DATA[3:0];
                end else begin
                    m_wait++;
                    if (TMO && m_wait == LAT) begin
                        m_own    = 0;
                        exp_derr = 1;
                    end
                end
            end else if (m_own && BOUTTICKS == 2'd3) begin
                m_own = 0;
            end
            exp_rd   = m_own && !m_got;
            exp_dout = (m_own && m_got && (BOUTTICKS == 2'd1 || BOUTTICKS == 2'd2)) ? m_nib : 4'd0;
        end
    end

    // ---------------- per-cycle compare + monitor ----------------
    initial begin
        forever begin
            @(negedge MCLK);
            if (!nRESET) begin
                chk("rst_BUF_RD", {15'd0, BUF_RD}, 16'd0);
                chk("rst_DOUT", {12'd0, DOUT}, 16'd0);
                chk("rst_BUF_ADDR", {3'd0, BUF_ADDR}, 16'd0);
                chk("rst_DERR", {15'd0, DERR}, 16'd0);
            end else begin
                chk("BUF_RD", {15'd0, BUF_RD}, {15'd0, exp_rd});
                chk("DOUT", {12'd0, DOUT}, {12'd0, exp_dout});
                chk("DERR", {15'd0, DERR}, {15'd0, exp_derr});
                if (exp_rd) chk("BUF_ADDR", {3'd0, BUF_ADDR}, {3'd0, exp_addr});
            end
            if (BUF_RD) begin
                rd_seen   = 1;
                last_addr = BUF_ADDR;
            end
            if (DOUT != 4'd0) dout_nz = 1;
            if (DERR) derr_seen = 1;
        end
    end

    // ---------------- buffer responder ----------------
    initial begin
        int cnt;
        cnt      = 0;
        BUF_ACK  = 1'b0;
        BUF_DATA = 8'h00;
        forever begin
            @(negedge MCLK);
            BUF_ACK = 1'b0;
            if (nRESET && BUF_RD) begin
                cnt++;
                if (cnt == ack_lat + 1) begin
                    BUF_ACK  = 1'b1;
                    BUF_DATA = mem[BUF_ADDR];
                end
            end else begin
                cnt = 0;
                if (spurious && $urandom_range(0, 39) == 0) begin
                    BUF_ACK  = 1'b1;
                    BUF_DATA = 8'($urandom);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic phase(input logic [1:0] t, input int n);
        BOUTTICKS = t;
        repeat (n) @(negedge MCLK);
    endtask

    task automatic bubble_cycle(input logic [2:0] at, input logic [12:0] num,
                                input int lat, input int drop_at);
        ACCTYPE      = at;
        BOUTCYCLENUM = num;
        ack_lat      = lat;
        for (int c = 0; c < 4 * PH; c++) begin
            BOUTTICKS = 2'(c / PH);
            if (c == drop_at) ACCTYPE = ACC_IDLE;
            @(negedge MCLK);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[0]       = 8'hA5;
        mem[13'h1123] = 8'h3C;

        nRESET       = 1'b0;
        ACCTYPE      = ACC_STBY;
        BOUTCYCLENUM = 13'd8191;
        BOUTTICKS    = 2'd3;
        repeat (3) @(negedge MCLK);
        chk("reset_DOUT", {12'd0, DOUT}, 16'd0);
        chk("reset_BUF_RD", {15'd0, BUF_RD}, 16'd0);
        chk("reset_BUF_ADDR", {3'd0, BUF_ADDR}, 16'd0);
        chk("reset_DERR", {15'd0, DERR}, 16'd0);
        nRESET = 1'b1;
        repeat (3) @(negedge MCLK);

        // BOOT cycle 0, byte 0xA5, ACK 3 clk after request
        ACCTYPE = ACC_BOOT; BOUTCYCLENUM = 13'd0; ack_lat = 3;
        BOUTTICKS = 2'd0;
        @(negedge MCLK);
        chk("t1_rd_after_1clk", {15'd0, BUF_RD}, 16'd0);
        @(negedge MCLK);
        chk("t1_rd_after_2clk", {15'd0, BUF_RD}, 16'd1);
        chk("t1_addr", {3'd0, BUF_ADDR}, 16'h0000);
        repeat (PH - 2) @(negedge MCLK);
        BOUTTICKS = 2'd1;
        @(negedge MCLK);
        chk("t1_dout_tick1", {12'd0, DOUT}, 16'h5);
        repeat (PH - 1) @(negedge MCLK);
        phase(2'd2, PH);
        chk("t1_dout_tick2", {12'd0, DOUT}, 16'h5);
        BOUTTICKS = 2'd3;
        @(negedge MCLK);
        chk("t1_dout_tick3", {12'd0, DOUT}, 16'h0);
        repeat (PH - 1) @(negedge MCLK);

        // USER cycle 583, byte 0x3C -> address 0x1123, high nibble
        ACCTYPE = ACC_USER; BOUTCYCLENUM = 13'd583; ack_lat = 5;
        phase(2'd0, PH);
        chk("t2_addr", {3'd0, last_addr}, 16'h1123);
        phase(2'd1, PH);
        chk("t2_dout_tick1", {12'd0, DOUT}, 16'h3);
        phase(2'd2, PH);
        chk("t2_dout_tick2", {12'd0, DOUT}, 16'h3);
        phase(2'd3, PH);
        chk("t2_dout_tick3", {12'd0, DOUT}, 16'h0);

        // invalid cycle number: no request, no data
        rd_seen = 0; dout_nz = 0;
        bubble_cycle(ACC_BOOT, 13'd8191, 3, -1);
        chk("t3_rd_seen", {15'd0, rd_seen}, 16'd0);
        chk("t3_dout_nz", {15'd0, dout_nz}, 16'd0);

        // ACK withheld 130 clk
        derr_seen = 0;
        ACCTYPE = ACC_BOOT; BOUTCYCLENUM = 13'd0; ack_lat = 130;
        phase(2'd0, PH);
        phase(2'd1, PH);
        chk("t4_dout_late_tick1", {12'd0, DOUT}, TMO ? 16'h0 : 16'h5);
        phase(2'd2, PH);
        chk("t4_dout_late_tick2", {12'd0, DOUT}, TMO ? 16'h0 : 16'h5);
        phase(2'd3, PH);
        chk("t4_derr_seen", {15'd0, derr_seen}, {15'd0, TMO});

        // ACCTYPE 111 -> 100 mid-drive
        ACCTYPE = ACC_USER; BOUTCYCLENUM = 13'd583; ack_lat = 3;
        phase(2'd0, PH);
        phase(2'd1, 20);
        chk("t5_dout_before_drop", {12'd0, DOUT}, 16'h3);
        ACCTYPE = ACC_IDLE;
        @(negedge MCLK);
        chk("t5_dout_after_drop", {12'd0, DOUT}, 16'h0);
        chk("t5_rd_after_drop", {15'd0, BUF_RD}, 16'd0);
        dout_nz = 0;
        repeat (PH - 21) @(negedge MCLK);
        phase(2'd2, PH);
        phase(2'd3, PH);
        chk("t5_dout_stays_0", {15'd0, dout_nz}, 16'd0);

        // reset asserted while waiting in S_REQ
        ACCTYPE = ACC_USER; BOUTCYCLENUM = 13'd583; ack_lat = 1000;
        phase(2'd0, 10);
        chk("t6_rd_before_reset", {15'd0, BUF_RD}, 16'd1);
        @(posedge MCLK);
        #2 nRESET = 1'b0;
        #1;
        chk("t6_rd_in_reset", {15'd0, BUF_RD}, 16'd0);
        chk("t6_addr_in_reset", {3'd0, BUF_ADDR}, 16'd0);
        chk("t6_dout_in_reset", {12'd0, DOUT}, 16'd0);
        chk("t6_derr_in_reset", {15'd0, DERR}, 16'd0);
        @(negedge MCLK);
        repeat (PH - 12) @(negedge MCLK);
        phase(2'd1, PH);
        nRESET = 1'b1;
        rd_seen = 0;
        ack_lat = 3;
        phase(2'd2, PH);
        phase(2'd3, PH);
        chk("t6_no_fetch_before_tick0", {15'd0, rd_seen}, 16'd0);
        phase(2'd0, PH);
        chk("t6_fetch_at_tick0", {15'd0, rd_seen}, 16'd1);
        phase(2'd1, PH);
        phase(2'd2, PH);
        phase(2'd3, PH);

        // tick glitch 0->1->0 restarts the fetch for the new cycle number
        ACCTYPE = ACC_BOOT; BOUTCYCLENUM = 13'd0; ack_lat = 3;
        phase(2'd0, 30);
        phase(2'd1, 10);
        BOUTCYCLENUM = 13'd2;
        phase(2'd0, PH);
        chk("t7_restart_addr", {3'd0, last_addr}, 16'h0001);
        phase(2'd1, PH);
        chk("t7_restart_dout", {12'd0, DOUT}, {12'd0, mem[1][3:0]});
        phase(2'd2, PH);
        phase(2'd3, PH);

        // randomized bubble cycles
        spurious = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic [2:0]  at;
            logic [12:0] num;
            int          lat, drop, sel;
            sel = $urandom_range(0, 9);
            at  = (sel < 4) ? ACC_BOOT : (sel < 8) ? ACC_USER : (sel == 8) ? ACC_IDLE : ACC_SWAP;
            num = ($urandom_range(0, 9) == 0) ? 13'd8191 : 13'($urandom_range(0, 8190));
            sel = $urandom_range(0, 9);
            lat = (sel < 6) ? $urandom_range(0, 20) : (sel < 9) ? $urandom_range(95, 240) : 1000;
            drop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4 * PH - 1) : -1;
            bubble_cycle(at, num, lat, drop);
        end
        spurious = 1'b0;
        repeat (4) @(negedge MCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
